// File: rtl/eth_serdes_chan_pkg.sv
// Shared definitions for the SERDES channel model: block geometry, sync header codes,
// LFSR feedback taps and the error-injection FSM state type.
package eth_serdes_chan_pkg;

  // One 64b/66b block: 64 payload bits plus a 2-bit sync header.
  localparam int unsigned BlockWidth = 66;

  // Legal sync header codes.
  localparam logic [1:0] SyncData = 2'b01;
  localparam logic [1:0] SyncCtrl = 2'b10;

  // x^32 + x^22 + x^2 + x + 1, as a mask over state bits [31], [21], [1] and [0].
  localparam logic [31:0] LfsrTaps = 32'h8020_0003;

  typedef enum logic [0:0] {
    StIdle,
    StBurst
  } inj_state_e;

endpackage

// File: rtl/eth_serdes_chan_lfsr.sv
// 32-bit Fibonacci LFSR that advances every cycle.
//   clk_i   : clock
//   rst_i   : synchronous active-high reset, loads Seed
//   state_o : current LFSR state
module eth_serdes_chan_lfsr
  import eth_serdes_chan_pkg::*;
#(
  parameter logic [31:0] Seed = 32'h0000_0001
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] state_o
);

  logic [31:0] state_d, state_q;

  // Shift towards the MSB; the XOR of the tapped bits enters at bit 0.
  always_comb begin
    state_d = {state_q[30:0], ^(state_q & LfsrTaps)};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= Seed;
    end else begin
      state_q <= state_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/eth_serdes_chan.sv
// Loopback SERDES channel model: re-aligns the TX block stream by a bitslip-controlled offset
// and optionally corrupts sync headers in LFSR-driven bursts.
//   rx_clk / rx_rst         : clock, synchronous active-high reset
//   in_data / in_hdr        : block from PHY TX
//   serdes_rx_bitslip       : rising edge advances the alignment offset by one bit
//   cfg_err_thresh          : inject when lfsr[15:0] < thresh (0 disables)
//   cfg_err_burst           : blocks corrupted per injection event (0 acts as 1)
//   cfg_bad_hdr_sel         : 0 -> bad header all ones, 1 -> all zeros
//   out_data / out_hdr      : re-aligned (and possibly corrupted) block to PHY RX
//   slip_offset             : current alignment offset, 0..65
//   stat_blocks / stat_injected : saturating block and corruption counters
// DATA_WIDTH + HDR_WIDTH must equal BlockWidth.
module eth_serdes_chan
  import eth_serdes_chan_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned HDR_WIDTH  = 2,
  parameter logic [31:0] LFSR_SEED  = 32'h0000_0001
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  serdes_rx_bitslip,
  input  logic [15:0]           cfg_err_thresh,
  input  logic [7:0]            cfg_err_burst,
  input  logic                  cfg_bad_hdr_sel,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic [6:0]            slip_offset,
  output logic [31:0]           stat_blocks,
  output logic [31:0]           stat_injected
);

  localparam logic [6:0] MaxOffset = 7'(BlockWidth - 1);

  logic [BlockWidth-1:0]   w_d, w_cur_q;
  logic [2*BlockWidth-1:0] window;
  logic [BlockWidth-1:0]   blk;
  logic                    slip_q;
  logic [6:0]              offset_d, offset_q;
  logic [DATA_WIDTH-1:0]   out_data_d, out_data_q;
  logic [HDR_WIDTH-1:0]    out_hdr_d, out_hdr_q;
  logic [31:0]             blocks_d, blocks_q;
  logic [31:0]             injected_d, injected_q;
  inj_state_e              state_d, state_q;
  logic [7:0]              burst_cnt_d, burst_cnt_q;
  logic [7:0]              burst_len;
  logic                    corrupt;
  logic [31:0]             lfsr;
  logic                    unused_lfsr;

  eth_serdes_chan_lfsr #(
    .Seed (LFSR_SEED)
  ) u_lfsr (
    .clk_i   (rx_clk),
    .rst_i   (rx_rst),
    .state_o (lfsr)
  );

  assign unused_lfsr = ^lfsr[31:16];

  // The output register is loaded from the window as it will stand after this edge:
  // the incoming word becomes w_cur and the current w_cur becomes w_prev. Selecting from
  // {w_d, w_cur_q} gives two cycles of latency at offset 0 without a separate w_prev store.
  assign w_d    = {in_data, in_hdr};
  assign window = {w_d, w_cur_q};
  assign blk    = window[{1'b0, offset_q} +: BlockWidth];

  // Bitslip: act on the rising edge only; the new offset applies from the next block.
  always_comb begin
    offset_d = offset_q;
    if (serdes_rx_bitslip && !slip_q) begin
      offset_d = (offset_q == MaxOffset) ? 7'd0 : offset_q + 7'd1;
    end
  end

  // Injection FSM. The burst length is latched at the event so later cfg changes
  // cannot shorten it.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    corrupt     = 1'b0;
    burst_len   = (cfg_err_burst == 8'd0) ? 8'd1 : cfg_err_burst;
    case (state_q)
      StIdle: begin
        if (lfsr[15:0] < cfg_err_thresh) begin
          corrupt     = 1'b1;
          burst_cnt_d = burst_len - 8'd1;
          if (burst_len != 8'd1) begin
            state_d = StBurst;
          end
        end
      end
      StBurst: begin
        corrupt     = 1'b1;
        burst_cnt_d = burst_cnt_q - 8'd1;
        if (burst_cnt_q == 8'd1) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    out_data_d = blk[BlockWidth-1:HDR_WIDTH];
    out_hdr_d  = blk[HDR_WIDTH-1:0];
    if (corrupt) begin
      out_hdr_d = cfg_bad_hdr_sel ? {HDR_WIDTH{1'b0}} : {HDR_WIDTH{1'b1}};
    end
    blocks_d   = (blocks_q == 32'hFFFF_FFFF) ? blocks_q : blocks_q + 32'd1;
    injected_d = injected_q;
    if (corrupt && (injected_q != 32'hFFFF_FFFF)) begin
      injected_d = injected_q + 32'd1;
    end
  end

  always_ff @(posedge rx_clk) begin
    if (rx_rst) begin
      w_cur_q     <= '0;
      slip_q      <= 1'b0;
      offset_q    <= 7'd0;
      out_data_q  <= '0;
      out_hdr_q   <= '0;
      blocks_q    <= 32'd0;
      injected_q  <= 32'd0;
      state_q     <= StIdle;
      burst_cnt_q <= 8'd0;
    end else begin
      w_cur_q     <= w_d;
      slip_q      <= serdes_rx_bitslip;
      offset_q    <= offset_d;
      out_data_q  <= out_data_d;
      out_hdr_q   <= out_hdr_d;
      blocks_q    <= blocks_d;
      injected_q  <= injected_d;
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign out_data      = out_data_q;
  assign out_hdr       = out_hdr_q;
  assign slip_offset   = offset_q;
  assign stat_blocks   = blocks_q;
  assign stat_injected = injected_q;

endmodule

// File: tb/tb_eth_serdes_chan.sv
// Scoreboard bench for eth_serdes_chan: the driver pushes reference-model expectations,
// a monitor pops and compares one entry per clock.
module tb_eth_serdes_chan;

  localparam logic [31:0] Seed = 32'h0000_0001;

  logic        clk = 1'b0;
  logic        rx_rst;
  logic [63:0] in_data;
  logic [1:0]  in_hdr;
  logic        bitslip;
  logic [15:0] thresh;
  logic [7:0]  burst;
  logic        sel;
  logic [63:0] out_data;
  logic [1:0]  out_hdr;
  logic [6:0]  slip_offset;
  logic [31:0] stat_blocks;
  logic [31:0] stat_injected;

  always #5 clk = ~clk;

  eth_serdes_chan #(
    .DATA_WIDTH (64),
    .HDR_WIDTH  (2),
    .LFSR_SEED  (Seed)
  ) dut (
    .rx_clk            (clk),
    .rx_rst            (rx_rst),
    .in_data           (in_data),
    .in_hdr            (in_hdr),
    .serdes_rx_bitslip (bitslip),
    .cfg_err_thresh    (thresh),
    .cfg_err_burst     (burst),
    .cfg_bad_hdr_sel   (sel),
    .out_data          (out_data),
    .out_hdr           (out_hdr),
    .slip_offset       (slip_offset),
    .stat_blocks       (stat_blocks),
    .stat_injected     (stat_injected)
  );

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  hdr;
    logic [6:0]  off;
    logic [31:0] blocks;
    logic [31:0] inj;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state: previous word, bit offset, last bitslip level, LFSR value,
  // remaining blocks of the current burst, and the two counters.
  logic [65:0] m_prev_w;
  int          m_off;
  bit          m_prev_slip;
  logic [31:0] m_lfsr;
  int          m_remaining;
  logic [31:0] m_blocks;
  logic [31:0] m_inj;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    int   taps[4];
    logic fb;
    taps = '{32, 22, 2, 1};
    fb   = 1'b0;
    foreach (taps[i]) fb ^= s[taps[i]-1];
    return {s[30:0], fb};
  endfunction

  task automatic model_step();
    exp_t         e;
    logic [65:0]  w;
    logic [131:0] sh;
    logic [65:0]  b;
    bit           corrupt;
    if (rx_rst) begin
      m_prev_w    = '0;
      m_off       = 0;
      m_prev_slip = 0;
      m_lfsr      = Seed;
      m_remaining = 0;
      m_blocks    = 0;
      m_inj       = 0;
      e           = '0;
    end else begin
      w  = {in_data, in_hdr};
      sh = {w, m_prev_w} >> m_off;
      b  = sh[65:0];
      corrupt = 0;
      if (m_remaining > 0) begin
        corrupt = 1;
        m_remaining--;
      end else if (m_lfsr[15:0] < thresh) begin
        corrupt = 1;
        m_remaining = ((burst == 0) ? 1 : int'(burst)) - 1;
      end
      e.data = b[65:2];
      e.hdr  = corrupt ? (sel ? 2'b00 : 2'b11) : b[1:0];
      if (bitslip && !m_prev_slip) m_off = (m_off + 1) % 66;
      m_prev_slip = bitslip;
      m_lfsr      = lfsr_next(m_lfsr);
      if (m_blocks != 32'hFFFF_FFFF) m_blocks++;
      if (corrupt && m_inj != 32'hFFFF_FFFF) m_inj++;
      m_prev_w = w;
      e.off    = 7'(m_off);
      e.blocks = m_blocks;
      e.inj    = m_inj;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit rst, input logic [63:0] d, input logic [1:0] h, input bit slip,
                       input logic [15:0] th, input logic [7:0] bu, input bit sl);
    @(negedge clk);
    rx_rst  = rst;
    in_data = d;
    in_hdr  = h;
    bitslip = slip;
    thresh  = th;
    burst   = bu;
    sel     = sl;
    model_step();
  endtask

  // Let the edge for the last drive happen so DUT outputs match the model state.
  task automatic settle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every clock the DUT presents one block; compare it with the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_hdr", out_hdr, e.hdr);
        chk("slip_offset", slip_offset, e.off);
        chk("stat_blocks", stat_blocks, e.blocks);
        chk("stat_injected", stat_injected, e.inj);
      end
    end
  end

  initial begin
    logic [63:0] cd;
    logic [15:0] rth;
    logic [7:0]  rbu;
    bit          rsel;
    rx_rst = 1; in_data = 0; in_hdr = 0; bitslip = 0; thresh = 0; burst = 0; sel = 0;

    // Constant control blocks, injection disabled.
    repeat (2) drive(1, 64'h0707070707070707, 2'b10, 0, 16'h0, 8'd0, 0);
    repeat (20) drive(0, 64'h0707070707070707, 2'b10, 0, 16'h0, 8'd0, 0);
    settle();
    chk("const_data", out_data, 64'h0707070707070707);
    chk("const_hdr", out_hdr, 2'b10);
    chk("const_noinj", stat_injected, 32'd0);

    // Single bitslip pulse on an all-zero data stream.
    repeat (2) drive(1, 64'h0, 2'b01, 0, 16'h0, 8'd0, 0);
    repeat (4) drive(0, 64'h0, 2'b01, 0, 16'h0, 8'd0, 0);
    drive(0, 64'h0, 2'b01, 1, 16'h0, 8'd0, 0);
    repeat (5) drive(0, 64'h0, 2'b01, 0, 16'h0, 8'd0, 0);
    settle();
    chk("slip1_offset", slip_offset, 7'd1);
    chk("slip1_hdr", out_hdr, 2'b00);
    chk("slip1_data", out_data, 64'h8000_0000_0000_0000);

    // 66 pulses wrap the offset; then a held level counts once.
    cd = {$urandom, $urandom};
    repeat (2) drive(1, cd, 2'b01, 0, 16'h0, 8'd0, 0);
    repeat (3) drive(0, cd, 2'b01, 0, 16'h0, 8'd0, 0);
    repeat (66) begin
      drive(0, cd, 2'b01, 1, 16'h0, 8'd0, 0);
      drive(0, cd, 2'b01, 0, 16'h0, 8'd0, 0);
    end
    repeat (3) drive(0, cd, 2'b01, 0, 16'h0, 8'd0, 0);
    settle();
    chk("wrap_offset", slip_offset, 7'd0);
    chk("wrap_data", out_data, cd);
    chk("wrap_hdr", out_hdr, 2'b01);
    repeat (10) drive(0, cd, 2'b01, 1, 16'h0, 8'd0, 0);
    settle();
    chk("held_offset", slip_offset, 7'd1);
    drive(0, cd, 2'b01, 0, 16'h0, 8'd0, 0);

    // Near-always injection, burst 1, header forced to 11.
    repeat (2) drive(1, 64'h0, 2'b01, 0, 16'hFFFF, 8'd1, 0);
    repeat (1000) drive(0, {$urandom, $urandom}, 2'(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10),
                        0, 16'hFFFF, 8'd1, 0);
    settle();
    chk("thresh_max_injected", stat_injected, m_inj);

    // One event of burst 3, coinciding with a bitslip edge.
    repeat (2) drive(1, 64'h0, 2'b01, 0, 16'h0, 8'd3, 1);
    drive(0, {$urandom, $urandom}, 2'b01, 1, 16'hFFFF, 8'd3, 1);
    repeat (10) drive(0, {$urandom, $urandom}, 2'b10, 0, 16'h0, 8'd3, 1);
    settle();
    chk("burst3_injected", stat_injected, 32'd3);
    chk("burst3_offset", slip_offset, 7'd1);

    // Reset in the middle of a long burst.
    repeat (2) drive(1, 64'h0, 2'b01, 0, 16'h0, 8'd200, 0);
    drive(0, {$urandom, $urandom}, 2'b01, 1, 16'hFFFF, 8'd200, 0);
    repeat (5) drive(0, {$urandom, $urandom}, 2'b01, 0, 16'h0, 8'd200, 0);
    drive(1, {$urandom, $urandom}, 2'b01, 0, 16'h0, 8'd200, 0);
    settle();
    chk("rst_blocks", stat_blocks, 32'd0);
    chk("rst_injected", stat_injected, 32'd0);
    chk("rst_offset", slip_offset, 7'd0);
    chk("rst_hdr", out_hdr, 2'b00);
    repeat (40) drive(0, {$urandom, $urandom}, 2'b01, 0, 16'h2000, 8'd2, 1);

    // Randomized traffic with changing configuration and occasional resets.
    rth = 0; rbu = 0; rsel = 0;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 3))
          0:       rth = 16'h0;
          1:       rth = 16'h0800;
          2:       rth = 16'h4000;
          default: rth = 16'($urandom);
        endcase
        rbu  = 8'($urandom_range(0, 6));
        rsel = 1'($urandom_range(0, 1));
      end
      drive(($urandom_range(0, 399) == 0), {$urandom, $urandom}, 2'($urandom_range(0, 3)),
            ($urandom_range(0, 5) == 0), rth, rbu, rsel);
    end
    settle();
    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/eth_serdes_chan.md
ETH_SERDES_CHAN -- requirements
Module: eth_serdes_chan

Interface
REQ-001 Parameters SHALL be: DATA_WIDTH, default 64, block payload width; HDR_WIDTH, default 2, sync header width; LFSR_SEED, default 32'h0000_0001, non-zero injection LFSR seed.
REQ-002 The block SHALL have one clock, rx_clk; reset is rx_rst, synchronous and active-high.
REQ-003 Ports SHALL be, in order:
- rx_clk  in  1  sole clock
- rx_rst  in  1  synchronous active-high reset
- in_data  in  DATA_WIDTH  block payload from PHY TX (serdes_tx_data)
- in_hdr  in  HDR_WIDTH  sync header from PHY TX (serdes_tx_hdr)
- serdes_rx_bitslip  in  1  bitslip request from PHY RX
- cfg_err_thresh  in  16  injection threshold; 0 disables injection
- cfg_err_burst  in  8  blocks corrupted per injection event; 0 treated as 1
- cfg_bad_hdr_sel  in  1  0: corrupt header to 2'b11; 1: to 2'b00
- out_data  out  DATA_WIDTH  payload to PHY RX (serdes_rx_data)
- out_hdr  out  HDR_WIDTH  header to PHY RX (serdes_rx_hdr)
- slip_offset  out  7  current alignment offset, 0..65
- stat_blocks  out  32  blocks output since reset
- stat_injected  out  32  corrupted blocks since reset

Function
REQ-004 Each cycle the block SHALL form w = {in_data, in_hdr} (66 bits; bit 0 = in_hdr[0], first on the wire) and register it as w_cur, moving the old w_cur to w_prev.
REQ-005 Output block b SHALL be bits [offset+65:offset] of {w_cur, w_prev}; out_hdr = b[1:0], out_data = b[65:2]; out_* registered; latency from in_* to out_* is 2 cycles at offset 0.
REQ-006 A rising edge of serdes_rx_bitslip (low previous cycle, high this cycle) SHALL increment offset by 1, wrapping 65 -> 0; a level held high SHALL count once; the new offset takes effect on the next output block.
REQ-007 A 32-bit Fibonacci LFSR, polynomial x^32+x^22+x^2+x+1, SHALL advance every cycle from LFSR_SEED.
REQ-008 Injection FSM states SHALL be IDLE and BURST; in IDLE, lfsr[15:0] < cfg_err_thresh -> corrupt this block, load burst_cnt = max(cfg_err_burst,1)-1, go to BURST if burst_cnt != 0.
REQ-009 In BURST every block SHALL be corrupted and burst_cnt decremented; at burst_cnt == 1 the FSM returns to IDLE; cfg changes mid-burst SHALL NOT shorten the burst.
REQ-010 Corruption SHALL replace out_hdr only (2'b11 or 2'b00 per cfg_bad_hdr_sel, sampled on the same cycle); out_data SHALL be unaltered.
REQ-011 stat_blocks SHALL increment on every cycle after reset and stat_injected on every corrupted block; both SHALL saturate at 32'hFFFF_FFFF.
REQ-012 A bitslip edge coinciding with an injection event SHALL apply both; neither is dropped.

Reset
REQ-013 While rx_rst is high: out_data = 0, out_hdr = 2'b00, w_cur = w_prev = 0, offset = 0, bitslip edge register = 0, LFSR = LFSR_SEED, FSM = IDLE, burst_cnt = 0, both counters 0.
REQ-014 Reset asserted mid-burst SHALL abort the burst; the first post-reset output SHALL be uncorrupted unless a new IDLE event fires.

Structure
REQ-015 A shared package SHALL hold the 66-bit block width constant, sync header codes (2'b01 data, 2'b10 control), the LFSR polynomial taps and the FSM state enum.
REQ-016 The LFSR SHALL be one sub-module, eth_serdes_chan_lfsr (seed parameter, advance every cycle, 32-bit state output).

Verification
REQ-017 thresh=0, offset 0, in_data=64'h0707070707070707, in_hdr=2'b10 constant -> identical out_* from cycle 2 after reset; stat_injected=0.
REQ-018 One bitslip pulse, constant in_data=0, in_hdr=2'b01 -> slip_offset=1, out_hdr=2'b00, out_data=64'h8000_0000_0000_0000.
REQ-019 66 bitslip pulses -> slip_offset=0 and output equals input; bitslip held high 10 cycles -> slip_offset increments by exactly 1.
REQ-020 thresh=16'hFFFF, burst=1, sel=0 for 1000 cycles -> every out_hdr with lfsr[15:0]!=16'hFFFF equals 2'b11, out_data unchanged, stat_injected matches a reference-model count.
REQ-021 burst=3 with one event, thresh forced to 0 the cycle after -> exactly 3 consecutive blocks with corrupted header, stat_injected=3.
REQ-022 rx_rst pulsed mid-burst -> next cycle all outputs/counters 0, slip_offset=0, LFSR sequence restarts from LFSR_SEED.
